// File: rtl/cpu_types_pkg.sv
// Shared types for the dual-core memory arbiter: RAM handshake state, data word,
// arbiter FSM state and the kind of request currently holding the grant.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE  = 2'd1,
    SCFAIL = 2'd2
  } arb_state_t;

  typedef enum logic [2:0] {
    GT_INSTR = 3'd0,
    GT_READ  = 3'd1,
    GT_WRITE = 3'd2,
    GT_LL    = 3'd3,
    GT_SC    = 3'd4
  } grant_t;

  localparam word_t SC_PASS = 32'd1;

  function automatic logic gt_is_write(grant_t t);
    return (t == GT_WRITE) || (t == GT_SC);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response bundle plus the single shared RAM port.
// master = cores and RAM, slave = the arbiter.
interface mem_arbiter_if #(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
);
  import cpu_types_pkg::*;

  logic [CPUS-1:0]             iREN;
  logic [CPUS-1:0][ADDR_W-1:0] iaddr;
  logic [CPUS-1:0]             iwait;
  logic [CPUS-1:0][31:0]       iload;

  logic [CPUS-1:0]             dREN;
  logic [CPUS-1:0]             dWEN;
  logic [CPUS-1:0]             datomic;
  logic [CPUS-1:0][ADDR_W-1:0] daddr;
  logic [CPUS-1:0][31:0]       dstore;
  logic [CPUS-1:0]             dwait;
  logic [CPUS-1:0][31:0]       dload;

  logic                        ramREN;
  logic                        ramWEN;
  logic [ADDR_W-1:0]           ramaddr;
  word_t                       ramstore;
  word_t                       ramload;
  ramstate_t                   ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, datomic, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter_rr_picker.sv
// Two-way round-robin pick: a lone requester always wins, a tie goes to ptr_i,
// the core after the last one granted.
module rr_picker (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = '0;
    if (req_i == 2'b11) gnt_o[ptr_i] = 1'b1;
    else                gnt_o = req_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two cores' instruction and data ports onto one RAM port, with
// per-core LL/SC link registers. Built for exactly two cores.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS   = 2,
  parameter int ADDR_W = 32
) (
  input logic          CLK,
  input logic          nRST,
  mem_arbiter_if.slave bus
);

  localparam int LA_W = ADDR_W - 2;

  arb_state_t                state_q;
  grant_t                    gtype_q;
  logic                      gcore_q;
  logic                      rr_q;
  logic [CPUS-1:0]           link_v_q;
  logic [CPUS-1:0][LA_W-1:0] link_a_q;
  logic                      ram_ren_q;
  logic                      ram_wen_q;
  logic [ADDR_W-1:0]         ram_addr_q;
  word_t                     ram_store_q;

  logic [CPUS-1:0]   dreq;
  logic [CPUS-1:0]   pick_req;
  logic [CPUS-1:0]   pick_gnt;
  logic [CPUS-1:0]   gsel;
  logic              use_data;
  logic              win_core;
  logic              win_sc_ok;
  logic              access;
  grant_t            win_type;
  logic [ADDR_W-1:0] win_addr;

  // Data requests shadow instruction fetches entirely; RR only breaks core ties.
  assign dreq     = bus.dREN | bus.dWEN;
  assign use_data = |dreq;
  assign pick_req = use_data ? dreq : bus.iREN;

  rr_picker u_rr (
    .req_i (pick_req),
    .ptr_i (rr_q),
    .gnt_o (pick_gnt)
  );

  assign win_core  = pick_gnt[1];
  assign win_addr  = use_data ? bus.daddr[win_core] : bus.iaddr[win_core];
  assign win_sc_ok = link_v_q[win_core] &&
                     (link_a_q[win_core] == win_addr[ADDR_W-1:2]);
  assign access    = (state_q == SERVE) && (bus.ramstate == ACCESS);
  assign gsel      = CPUS'(1) << gcore_q;

  always_comb begin
    win_type = GT_INSTR;
    if (use_data) begin
      if (bus.dWEN[win_core]) win_type = bus.datomic[win_core] ? GT_SC : GT_WRITE;
      else                    win_type = bus.datomic[win_core] ? GT_LL : GT_READ;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      gtype_q     <= GT_INSTR;
      gcore_q     <= 1'b0;
      rr_q        <= 1'b0;
      link_v_q    <= '0;
      link_a_q    <= '0;
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|pick_gnt) begin
            gcore_q <= win_core;
            gtype_q <= win_type;
            // A doomed SC never touches RAM; it is answered in SCFAIL.
            if (win_type == GT_SC && !win_sc_ok) begin
              state_q <= SCFAIL;
            end else begin
              state_q     <= SERVE;
              ram_ren_q   <= !gt_is_write(win_type);
              ram_wen_q   <= gt_is_write(win_type);
              ram_addr_q  <= win_addr;
              ram_store_q <= gt_is_write(win_type) ? bus.dstore[win_core] : '0;
            end
          end
        end
        SERVE: begin
          // BUSY and ERROR both just hold the strobes until RAM answers.
          if (bus.ramstate == ACCESS) begin
            state_q     <= IDLE;
            rr_q        <= ~gcore_q;
            ram_ren_q   <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_store_q <= '0;
            for (int c = 0; c < CPUS; c++) begin
              if (c == int'(gcore_q)) begin
                if (gtype_q == GT_LL) begin
                  link_v_q[c] <= 1'b1;
                  link_a_q[c] <= ram_addr_q[ADDR_W-1:2];
                end else if (gtype_q == GT_SC) begin
                  link_v_q[c] <= 1'b0;
                end
              end else if (gt_is_write(gtype_q) &&
                           link_a_q[c] == ram_addr_q[ADDR_W-1:2]) begin
                link_v_q[c] <= 1'b0;
              end
            end
          end
        end
        SCFAIL: begin
          state_q           <= IDLE;
          rr_q              <= ~gcore_q;
          link_v_q[gcore_q] <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ramREN   = ram_ren_q;
  assign bus.ramWEN   = ram_wen_q;
  assign bus.ramaddr  = ram_addr_q;
  assign bus.ramstore = ram_store_q;

  // Every requester waits by default; only the granted one is released, and only
  // in its completion cycle.
  always_comb begin
    bus.iwait = bus.iREN;
    bus.dwait = dreq;
    bus.iload = '0;
    bus.dload = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (gsel[c] && access) begin
        if (gtype_q == GT_INSTR) begin
          bus.iwait[c] = 1'b0;
          bus.iload[c] = bus.ramload;
        end else begin
          bus.dwait[c] = 1'b0;
          case (gtype_q)
            GT_SC:          bus.dload[c] = SC_PASS;
            GT_READ, GT_LL: bus.dload[c] = bus.ramload;
            default:        bus.dload[c] = '0;
          endcase
        end
      end
      if (gsel[c] && state_q == SCFAIL) bus.dwait[c] = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a RAM model with programmable latency/errors and a
// transaction-level model of memory contents and LL/SC links checked every cycle.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.CPUS(2), .ADDR_W(32)) bus ();

  mem_arbiter #(.CPUS(2), .ADDR_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic word_t pat(input logic [7:0] i);
    return 32'hC0DE_0000 | {24'd0, i};
  endfunction

  // ---------------- RAM model ----------------
  word_t      ram [256];
  bit [255:0] ram_wr = '0;
  int         lat = 2;
  bit         force_err = 1'b0;
  int         rcnt;
  int         wen_cnt = 0;

  function automatic word_t ram_rd(input logic [7:0] i);
    return ram_wr[i] ? ram[i] : pat(i);
  endfunction

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) rcnt <= 0;
    else if (!(bus.ramREN || bus.ramWEN) || bus.ramstate == ACCESS) rcnt <= 0;
    else rcnt <= rcnt + 1;
  end

  always @(posedge CLK) begin
    if (bus.ramWEN && bus.ramstate == ACCESS) begin
      ram[bus.ramaddr[9:2]]    <= bus.ramstore;
      ram_wr[bus.ramaddr[9:2]] <= 1'b1;
    end
  end

  always @(negedge CLK) if (bus.ramWEN) wen_cnt <= wen_cnt + 1;

  always_comb begin
    if (!(bus.ramREN || bus.ramWEN)) bus.ramstate = FREE;
    else if (force_err)              bus.ramstate = ERROR;
    else if (rcnt >= lat)            bus.ramstate = ACCESS;
    else                             bus.ramstate = BUSY;
    bus.ramload = ram_rd(bus.ramaddr[9:2]);
  end

  // ---------------- transaction-level model ----------------
  word_t       m_mem [256];
  bit [255:0]  m_wr = '0;
  bit          m_lv [2];
  logic [29:0] m_la [2];
  int          ndone;
  logic [31:0] ma;
  bit          ok;

  function automatic word_t m_rd(input logic [31:0] a);
    return m_wr[a[9:2]] ? m_mem[a[9:2]] : pat(a[9:2]);
  endfunction

  task automatic m_write(input int c, input logic [31:0] a, input word_t v);
    m_mem[a[9:2]] = v;
    m_wr[a[9:2]]  = 1'b1;
    for (int o = 0; o < 2; o++)
      if (o != c && m_la[o] == a[31:2]) m_lv[o] = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (!nRST) begin
      m_lv[0] = 1'b0;
      m_lv[1] = 1'b0;
    end else begin
      ndone = 0;
      for (int c = 0; c < 2; c++) begin
        if (bus.iREN[c] && !bus.iwait[c]) begin
          ndone++;
          chk($sformatf("iload%0d", c), bus.iload[c], m_rd(bus.iaddr[c]));
        end else if (!bus.iREN[c]) begin
          chk($sformatf("iwait_idle%0d", c), 32'(bus.iwait[c]), 32'd0);
        end
        if ((bus.dREN[c] || bus.dWEN[c]) && !bus.dwait[c]) begin
          ndone++;
          ma = bus.daddr[c];
          if (bus.dWEN[c] && bus.datomic[c]) begin
            ok = m_lv[c] && (m_la[c] == ma[31:2]);
            chk($sformatf("sc_result%0d", c), bus.dload[c], 32'(ok));
            if (ok) m_write(c, ma, bus.dstore[c]);
            m_lv[c] = 1'b0;
          end else if (bus.dWEN[c]) begin
            m_write(c, ma, bus.dstore[c]);
          end else begin
            chk($sformatf("dload%0d", c), bus.dload[c], m_rd(ma));
            if (bus.datomic[c]) begin
              m_lv[c] = 1'b1;
              m_la[c] = ma[31:2];
            end
          end
        end else if (!(bus.dREN[c] || bus.dWEN[c])) begin
          chk($sformatf("dwait_idle%0d", c), 32'(bus.dwait[c]), 32'd0);
        end
      end
      chk("one_done_per_cycle", 32'(ndone <= 1), 32'd1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(input bit isd, input int c, output int at, output word_t ld);
    at = -1;
    ld = '0;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (isd ? !bus.dwait[c] : !bus.iwait[c]) begin
        at = cyc;
        ld = isd ? bus.dload[c] : bus.iload[c];
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout_%s%0d: no completion in 50 cycles, want one", isd ? "d" : "i", c);
    end
    @(posedge CLK); #1;
  endtask

  task automatic dop(input int c, input bit wen, input bit atom, input logic [31:0] a,
                     input word_t st, output int t0, output int at, output word_t ld);
    t0 = cyc;
    bus.dREN[c]    = !wen;
    bus.dWEN[c]    = wen;
    bus.datomic[c] = atom;
    bus.daddr[c]   = a;
    bus.dstore[c]  = st;
    wait_done(1'b1, c, at, ld);
    bus.dREN[c]    = 1'b0;
    bus.dWEN[c]    = 1'b0;
    bus.datomic[c] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, at, at2, n, w0;
    word_t ld, ld2;
    int order [4];
    int tms [4];
    bus.iREN = '0; bus.dREN = '0; bus.dWEN = '0; bus.datomic = '0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    nRST = 1'b0;

    // reset values, with core0 fetching so its wait must read 1
    bus.iREN[0] = 1'b1;
    @(negedge CLK);
    chk("rst_ramREN",   32'(bus.ramREN), 32'd0);
    chk("rst_ramWEN",   32'(bus.ramWEN), 32'd0);
    chk("rst_ramaddr",  bus.ramaddr,     32'd0);
    chk("rst_ramstore", bus.ramstore,    32'd0);
    chk("rst_iwait0",   32'(bus.iwait[0]), 32'd1);
    chk("rst_iload0",   bus.iload[0],    32'd0);
    chk("rst_dload1",   bus.dload[1],    32'd0);
    bus.iREN[0] = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    @(posedge CLK); #1;

    // data beats instruction on the same core, RAM latency 2
    lat = 2;
    bus.iaddr[0] = 32'h0;
    bus.iREN[0]  = 1'b1;
    dop(0, 1'b0, 1'b0, 32'h100, 32'h0, t0, at, ld);
    chk("prio_d_latency", 32'(at - t0), 32'd3);
    chk("prio_d_load",    ld, 32'hC0DE_0040);
    wait_done(1'b0, 0, at2, ld2);
    chk("prio_i_after_d", 32'(at2 - at), 32'd4);
    chk("prio_i_load",    ld2, 32'hC0DE_0000);
    bus.iREN[0] = 1'b0;

    // a core1 read moves the RR pointer back to core0
    lat = 1;
    dop(1, 1'b0, 1'b0, 32'h44, 32'h0, t0, at, ld);
    chk("c1_read", ld, 32'hC0DE_0011);

    // both cores fetching continuously alternate
    order = '{-1, -1, -1, -1};
    tms   = '{0, 0, 0, 0};
    n = 0;
    bus.iaddr[0] = 32'h10;
    bus.iaddr[1] = 32'h20;
    bus.iREN = 2'b11;
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge CLK);
      for (int c = 0; c < 2; c++)
        if (!bus.iwait[c] && n < 4) begin
          order[n] = c;
          tms[n]   = cyc;
          n++;
        end
    end
    @(posedge CLK); #1;
    bus.iREN = '0;
    for (int i = 0; i < 4; i++) chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 2));
    for (int i = 0; i < 3; i++) chk($sformatf("rr_spacing%0d", i), 32'(tms[i+1] - tms[i]), 32'd3);

    // LL then matching SC succeeds and writes
    lat = 2;
    dop(0, 1'b0, 1'b1, 32'h40, 32'h0, t0, at, ld);
    chk("ll_load", ld, 32'hC0DE_0010);
    dop(0, 1'b1, 1'b1, 32'h40, 32'hA, t0, at, ld);
    chk("sc_pass_load", ld, 32'd1);
    chk("sc_pass_ram",  ram_rd(8'h10), 32'hA);
    dop(0, 1'b0, 1'b0, 32'h40, 32'h0, t0, at, ld);
    chk("sc_pass_readback", ld, 32'hA);

    // another core's store breaks the link; the SC fails without touching RAM
    dop(0, 1'b0, 1'b1, 32'h40, 32'h0, t0, at, ld);
    dop(1, 1'b1, 1'b0, 32'h40, 32'h55, t0, at, ld);
    chk("sw1_ram", ram_rd(8'h10), 32'h55);
    w0 = wen_cnt;
    dop(0, 1'b1, 1'b1, 32'h40, 32'hBB, t0, at, ld);
    chk("scfail_load",    ld, 32'd0);
    chk("scfail_latency", 32'(at - t0), 32'd1);
    chk("scfail_no_wen",  32'(wen_cnt - w0), 32'd0);
    chk("scfail_ram",     ram_rd(8'h10), 32'h55);

    // three ERROR cycles: grant and strobe held, completes on ACCESS
    lat = 1;
    force_err = 1'b1;
    t0 = cyc;
    bus.daddr[0] = 32'h80;
    bus.dREN[0]  = 1'b1;
    @(posedge CLK); #1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("err_ramREN%0d", k),  32'(bus.ramREN), 32'd1);
      chk($sformatf("err_ramaddr%0d", k), bus.ramaddr, 32'h80);
      chk($sformatf("err_dwait%0d", k),   32'(bus.dwait[0]), 32'd1);
    end
    @(posedge CLK); #1;
    force_err = 1'b0;
    wait_done(1'b1, 0, at, ld);
    bus.dREN[0] = 1'b0;
    chk("err_latency", 32'(at - t0), 32'd4);
    chk("err_load",    ld, 32'hC0DE_0020);

    // reset in the middle of a core1 LL drops it; the following SC fails
    lat = 3;
    bus.daddr[1]   = 32'h60;
    bus.datomic[1] = 1'b1;
    bus.dREN[1]    = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("llrst_ramREN_pre", 32'(bus.ramREN), 32'd1);
    chk("llrst_dwait_pre",  32'(bus.dwait[1]), 32'd1);
    #2 nRST = 1'b0;
    #1;
    chk("llrst_ramREN", 32'(bus.ramREN), 32'd0);
    chk("llrst_dwait",  32'(bus.dwait[1]), 32'd1);
    bus.dREN[1]    = 1'b0;
    bus.datomic[1] = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1;
    nRST = 1'b1;
    dop(1, 1'b1, 1'b1, 32'h60, 32'h77, t0, at, ld);
    chk("llrst_sc_load",    ld, 32'd0);
    chk("llrst_sc_latency", 32'(at - t0), 32'd1);
    chk("llrst_sc_ram",     ram_rd(8'h18), 32'hC0DE_0018);

    repeat (2) @(posedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter CPUS, default 2, number of cores; the design SHALL support exactly 2.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 CLK  in  1  clock; all state SHALL update on its rising edge.
REQ-004 nRST  in  1  reset, asynchronous, active-low.
REQ-005 iREN  in  [CPUS]  instruction-fetch read request per core.
REQ-006 iaddr  in  [CPUS][32]  instruction address per core.
REQ-007 iwait  out  [CPUS]  1 = instruction request not yet complete.
REQ-008 iload  out  [CPUS][32]  instruction data; valid only in the cycle iwait=0.
REQ-009 dREN, dWEN  in  [CPUS] each  data read/write request per core; both high SHALL be treated as a write.
REQ-010 daddr, dstore  in  [CPUS][32] each  data address and write data.
REQ-011 datomic  in  [CPUS]  1 with dREN = LL; 1 with dWEN = SC.
REQ-012 dwait  out  [CPUS]  1 = data request not yet complete.
REQ-013 dload  out  [CPUS][32]  read data, or SC result (1 success, 0 fail); valid only in the cycle dwait=0.
REQ-014 ramREN, ramWEN  out  1 each  RAM read/write strobe.
REQ-015 ramaddr, ramstore  out  32 each  RAM address and write data.
REQ-016 ramload  in  32  RAM read data.
REQ-017 ramstate  in  ramstate_t  FREE/BUSY/ACCESS/ERROR.

Function
REQ-018 FSM states: IDLE, SERVE, SCFAIL.
REQ-019 IDLE: with no request pending, SHALL stay in IDLE with ramREN=ramWEN=0.
REQ-020 IDLE arbitration SHALL pick the requester in this order: data over instruction; ties between cores SHALL go to the core after the last granted core (round-robin pointer).
REQ-021 The winner SHALL be registered into grant_core and grant_type. The FSM SHALL enter SERVE, or SCFAIL for an SC with no matching link.
REQ-022 SERVE: RAM outputs SHALL be driven only from the registered grant. The granted requester's wait SHALL stay 1 until the cycle ramstate==ACCESS.
REQ-023 In the cycle ramstate==ACCESS, the granted wait SHALL be 0 and load SHALL equal ramload (reads) or 1 (SC). The next state SHALL be IDLE and the RR pointer SHALL advance to the other core.
REQ-024 ramstate==ERROR or BUSY in SERVE SHALL hold the grant and strobes, retrying until ACCESS.
REQ-025 SCFAIL SHALL last 1 cycle with no RAM strobe, dwait=0 and dload=0 for the granted core, then return to IDLE.
REQ-026 All non-granted wait outputs SHALL be 1 whenever their request is asserted, and 0 when not requesting.
REQ-027 Minimum latency SHALL be request->grant 1 cycle, plus RAM latency. Back-to-back grants SHALL be separated by 1 IDLE cycle.
REQ-028 Link registers, per core: linkvalid, linkaddr[31:2].
REQ-029 LL completion SHALL set the core's own link to valid with linkaddr=daddr[31:2].
REQ-030 SC SHALL succeed only if linkvalid and daddr[31:2]==linkaddr. Any SC completion, pass or fail, SHALL clear the core's own link.
REQ-031 Any completed write, including SC, SHALL clear every other core's link whose linkaddr matches the write address.
REQ-032 A request deasserted while granted SHALL NOT be supported; behaviour in that case is undefined.

Reset
REQ-033 On nRST=0: state=IDLE, RR pointer=core 0, all links invalid, ramREN=ramWEN=0, ramaddr=ramstore=0, all wait outputs=1 if requesting, all load outputs=0.
REQ-034 Reset mid-SERVE SHALL drop the transaction; no link update SHALL occur.

Structure
REQ-035 ramstate_t, word_t and the arbiter state enum SHALL live in cpu_types_pkg.
REQ-036 Round-robin selection SHALL be one sub-module, rr_picker (2 requests + last pointer -> one-hot grant).

Verification
REQ-037 Core0 dREN and core0 iREN simultaneously, addr 0x100/0x0, RAM latency 2 -> data served first; dwait0=0 with ramload; iwait0=0 four cycles later.
REQ-038 Both cores iREN continuously -> grants alternate 0,1,0,1; neither core waits more than 2 transactions.
REQ-039 Core0 LL 0x40, then core0 SC 0x40 value 0xA -> dload0=1, RAM location 0x40 holds 0xA.
REQ-040 Core0 LL 0x40, core1 SW 0x40, then core0 SC 0x40 -> SCFAIL, no ramWEN, dload0=0.
REQ-041 ramstate=ERROR for 3 cycles during a read of 0x80 -> grant held, ramREN=1 throughout, completes on ACCESS.
REQ-042 nRST pulsed during SERVE of core1 LL -> IDLE, link1 invalid; a following core1 SC fails.
